// File: rtl/rename_register_file_if.sv
// Bundles issue-stage read/allocate, ROB commit and flush signals of the rename register file.
// Latency: none (wires only).
// Backpressure: none; master drives requests every cycle, slave answers combinationally.
interface rename_register_file_if #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int ROB_DEPTH  = 8,
  parameter int NUM_ISSUE  = 2,
  parameter int NUM_COMMIT = 2
);
  localparam int AW    = $clog2(NREGS);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CW    = AW + 1;

  // issue side
  logic [NUM_ISSUE-1:0][AW-1:0]    rs1_in;
  logic [NUM_ISSUE-1:0][AW-1:0]    rs2_in;
  logic [NUM_ISSUE-1:0]            issue_in;
  logic [NUM_ISSUE-1:0][AW-1:0]    rd_in;
  logic [NUM_ISSUE-1:0][TAG_W-1:0] rob_ix_in;
  // commit side
  logic [NUM_COMMIT-1:0]            commit_in;
  logic [NUM_COMMIT-1:0][AW-1:0]    commit_addr_in;
  logic [NUM_COMMIT-1:0][XLEN-1:0]  commit_data_in;
  logic [NUM_COMMIT-1:0][TAG_W-1:0] commit_rob_ix_in;
  logic                             flush_in;
  // read results
  logic [NUM_ISSUE-1:0][XLEN-1:0]  rval1_out;
  logic [NUM_ISSUE-1:0][XLEN-1:0]  rval2_out;
  logic [NUM_ISSUE-1:0][TAG_W-1:0] rob_ix1_out;
  logic [NUM_ISSUE-1:0][TAG_W-1:0] rob_ix2_out;
  logic [NUM_ISSUE-1:0]            rob1_valid_out;
  logic [NUM_ISSUE-1:0]            rob2_valid_out;
  logic [CW-1:0]                   pending_count_out;

  modport master (
    output rs1_in, rs2_in, issue_in, rd_in, rob_ix_in,
    output commit_in, commit_addr_in, commit_data_in, commit_rob_ix_in, flush_in,
    input  rval1_out, rval2_out, rob_ix1_out, rob_ix2_out,
    input  rob1_valid_out, rob2_valid_out, pending_count_out
  );

  modport slave (
    input  rs1_in, rs2_in, issue_in, rd_in, rob_ix_in,
    input  commit_in, commit_addr_in, commit_data_in, commit_rob_ix_in, flush_in,
    output rval1_out, rval2_out, rob_ix1_out, rob_ix2_out,
    output rob1_valid_out, rob2_valid_out, pending_count_out
  );
endinterface

// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB-tag rename state, x0 hardwired to zero.
// Latency: reads combinational (zero cycles); issue/commit/flush visible one cycle after the edge.
// Backpressure: none; all ports accepted every cycle. Optional macro RF_BYPASS_EN forwards commit data to pending reads.
module rename_register_file #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int ROB_DEPTH  = 8,
  parameter int NUM_ISSUE  = 2,
  parameter int NUM_COMMIT = 2
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  rename_register_file_if.slave rf
);
  localparam int AW    = $clog2(NREGS);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CW    = AW + 1;

  typedef struct packed {
    logic             pend;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } src_t;

  logic [XLEN-1:0]  val_q [NREGS];
  logic [TAG_W-1:0] tag_q [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [CW-1:0]    cnt_q;

  logic [XLEN-1:0]  val_d [NREGS];
  logic [TAG_W-1:0] tag_d [NREGS];
  logic [NREGS-1:0] pend_d;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    inc;
  logic [CW-1:0]    dec;

  src_t src_r [NUM_ISSUE][2];

  // Next state: commits write values (higher port last so it wins), then flush or issue overrides rename state.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    pend_d = pend_q;
    for (int j = 0; j < NUM_COMMIT; j++) begin
      if (rf.commit_in[j] && rf.commit_addr_in[j] != '0) begin
        val_d[rf.commit_addr_in[j]] = rf.commit_data_in[j];
        // Only the youngest producer may retire the pending bit; a stale tag leaves it set.
        if (rf.commit_rob_ix_in[j] == tag_q[rf.commit_addr_in[j]])
          pend_d[rf.commit_addr_in[j]] = 1'b0;
      end
    end
    if (rf.flush_in) begin
      pend_d = '0;
      for (int r = 0; r < NREGS; r++) tag_d[r] = '0;
    end else begin
      // Issue runs after commit so a same-cycle allocation re-arms the register; higher slot wins.
      for (int i = 0; i < NUM_ISSUE; i++) begin
        if (rf.issue_in[i] && rf.rd_in[i] != '0) begin
          tag_d[rf.rd_in[i]]  = rf.rob_ix_in[i];
          pend_d[rf.rd_in[i]] = 1'b1;
        end
      end
    end
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (pend_d[r] && !pend_q[r]) inc = inc + CW'(1);
      if (!pend_d[r] && pend_q[r]) dec = dec + CW'(1);
    end
    cnt_d = rf.flush_in ? '0 : cnt_q + inc - dec;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < NREGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Source reads: register state, overridden by intra-group rename, optionally bypassed from commit, x0 forced to zero.
  always_comb begin
    logic [AW-1:0] a;
    logic          ren;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      for (int s = 0; s < 2; s++) begin
        a   = (s == 0) ? rf.rs1_in[i] : rf.rs2_in[i];
        ren = 1'b0;
        src_r[i][s].pend = pend_q[a];
        src_r[i][s].tag  = tag_q[a];
        src_r[i][s].val  = val_q[a];
        for (int k = 0; k < i; k++) begin
          if (rf.issue_in[k] && !rf.flush_in && rf.rd_in[k] == a) begin
            ren = 1'b1;
            src_r[i][s].pend = 1'b1;
            src_r[i][s].tag  = rf.rob_ix_in[k];
          end
        end
`ifdef RF_BYPASS_EN
        if (!ren && pend_q[a]) begin
          for (int j = 0; j < NUM_COMMIT; j++) begin
            if (rf.commit_in[j] && rf.commit_addr_in[j] == a &&
                rf.commit_rob_ix_in[j] == tag_q[a]) begin
              src_r[i][s].pend = 1'b0;
              src_r[i][s].tag  = '0;
              src_r[i][s].val  = rf.commit_data_in[j];
            end
          end
        end
`else
        if (ren) src_r[i][s].pend = 1'b1;
`endif
        if (a == '0) src_r[i][s] = '0;
      end
    end
  end

  // Drive the read results out through the interface.
  always_comb begin
    for (int i = 0; i < NUM_ISSUE; i++) begin
      rf.rval1_out[i]      = src_r[i][0].val;
      rf.rob_ix1_out[i]    = src_r[i][0].tag;
      rf.rob1_valid_out[i] = src_r[i][0].pend;
      rf.rval2_out[i]      = src_r[i][1].val;
      rf.rob_ix2_out[i]    = src_r[i][1].tag;
      rf.rob2_valid_out[i] = src_r[i][1].pend;
    end
    rf.pending_count_out = cnt_q;
  end
endmodule

// File: tb/tb_rename_register_file.sv
// Bench for rename_register_file: directed scenarios then randomized traffic against a reference model.
// Latency: checks combinational reads mid-cycle, state effects the cycle after each edge.
// Backpressure: none exercised; the design accepts every cycle.
module tb_rename_register_file;
  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int ROB_DEPTH  = 8;
  localparam int NUM_ISSUE  = 2;
  localparam int NUM_COMMIT = 2;
  localparam int AW         = $clog2(NREGS);
  localparam int TAG_W      = $clog2(ROB_DEPTH);

  logic clk_in;
  logic rst_n_in;

  rename_register_file_if #(
    .XLEN(XLEN), .NREGS(NREGS), .ROB_DEPTH(ROB_DEPTH),
    .NUM_ISSUE(NUM_ISSUE), .NUM_COMMIT(NUM_COMMIT)
  ) rf_if ();

  rename_register_file #(
    .XLEN(XLEN), .NREGS(NREGS), .ROB_DEPTH(ROB_DEPTH),
    .NUM_ISSUE(NUM_ISSUE), .NUM_COMMIT(NUM_COMMIT)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .rf      (rf_if)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // reference architectural state
  logic [XLEN-1:0]  mval [NREGS];
  logic [TAG_W-1:0] mtag [NREGS];
  bit               mpend[NREGS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mcount();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(mpend[r]);
    return c;
  endfunction

  function automatic bit issued_to(input int a);
    for (int i = 0; i < NUM_ISSUE; i++)
      if (rf_if.issue_in[i] && int'(rf_if.rd_in[i]) == a) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_edge();
    logic [XLEN-1:0]  nval [NREGS];
    logic [TAG_W-1:0] ntag [NREGS];
    bit               npend[NREGS];
    int a;
    if (!rst_n_in) begin
      for (int r = 0; r < NREGS; r++) begin
        mval[r] = '0; mtag[r] = '0; mpend[r] = 1'b0;
      end
      return;
    end
    for (int r = 0; r < NREGS; r++) begin
      nval[r] = mval[r]; ntag[r] = mtag[r]; npend[r] = mpend[r];
    end
    for (int j = 0; j < NUM_COMMIT; j++) begin
      a = int'(rf_if.commit_addr_in[j]);
      if (rf_if.commit_in[j] && a != 0) nval[a] = rf_if.commit_data_in[j];
    end
    if (rf_if.flush_in) begin
      for (int r = 0; r < NREGS; r++) begin
        ntag[r] = '0; npend[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NUM_COMMIT; j++) begin
        a = int'(rf_if.commit_addr_in[j]);
        if (rf_if.commit_in[j] && a != 0 && rf_if.commit_rob_ix_in[j] == mtag[a] && !issued_to(a))
          npend[a] = 1'b0;
      end
      for (int i = 0; i < NUM_ISSUE; i++) begin
        a = int'(rf_if.rd_in[i]);
        if (rf_if.issue_in[i] && a != 0) begin
          ntag[a] = rf_if.rob_ix_in[i]; npend[a] = 1'b1;
        end
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      mval[r] = nval[r]; mtag[r] = ntag[r]; mpend[r] = npend[r];
    end
  endtask

  // Compare every read port and the counter against the model for the current inputs.
  task automatic check_reads();
    int a;
    logic [XLEN-1:0] ev;
    logic [TAG_W-1:0] et;
    bit ep, ren;
    #1;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      for (int s = 0; s < 2; s++) begin
        a   = (s == 0) ? int'(rf_if.rs1_in[i]) : int'(rf_if.rs2_in[i]);
        ev  = mval[a]; et = mtag[a]; ep = mpend[a]; ren = 1'b0;
        for (int k = 0; k < i; k++)
          if (rf_if.issue_in[k] && !rf_if.flush_in && int'(rf_if.rd_in[k]) == a) begin
            ren = 1'b1; ep = 1'b1; et = rf_if.rob_ix_in[k];
          end
`ifdef RF_BYPASS_EN
        if (!ren && mpend[a])
          for (int j = 0; j < NUM_COMMIT; j++)
            if (rf_if.commit_in[j] && int'(rf_if.commit_addr_in[j]) == a && rf_if.commit_rob_ix_in[j] == mtag[a]) begin
              ev = rf_if.commit_data_in[j]; ep = 1'b0; et = '0;
            end
`endif
        if (a == 0) begin
          ev = '0; et = '0; ep = 1'b0;
        end
        if (s == 0) begin
          check($sformatf("slot%0d_rs1_val", i), rf_if.rval1_out[i], ev);
          check($sformatf("slot%0d_rs1_pend", i), rf_if.rob1_valid_out[i], ep);
          if (ep) check($sformatf("slot%0d_rs1_tag", i), rf_if.rob_ix1_out[i], et);
        end else begin
          check($sformatf("slot%0d_rs2_val", i), rf_if.rval2_out[i], ev);
          check($sformatf("slot%0d_rs2_pend", i), rf_if.rob2_valid_out[i], ep);
          if (ep) check($sformatf("slot%0d_rs2_tag", i), rf_if.rob_ix2_out[i], et);
        end
      end
    end
    check("pending_count", rf_if.pending_count_out, mcount());
  endtask

  task automatic tick();
    check_reads();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  task automatic set_idle();
    rf_if.rs1_in = '0; rf_if.rs2_in = '0; rf_if.issue_in = '0;
    rf_if.rd_in = '0; rf_if.rob_ix_in = '0; rf_if.commit_in = '0;
    rf_if.commit_addr_in = '0; rf_if.commit_data_in = '0;
    rf_if.commit_rob_ix_in = '0; rf_if.flush_in = 1'b0;
  endtask

  task automatic do_issue(input int slot, input int rd, input int tag);
    rf_if.issue_in[slot]  = 1'b1;
    rf_if.rd_in[slot]     = AW'(rd);
    rf_if.rob_ix_in[slot] = TAG_W'(tag);
  endtask

  task automatic do_commit(input int port, input int rd, input int tag, input logic [XLEN-1:0] data);
    rf_if.commit_in[port]        = 1'b1;
    rf_if.commit_addr_in[port]   = AW'(rd);
    rf_if.commit_rob_ix_in[port] = TAG_W'(tag);
    rf_if.commit_data_in[port]   = data;
  endtask

  initial begin
    int a;
    for (int r = 0; r < NREGS; r++) begin
      mval[r] = '0; mtag[r] = '0; mpend[r] = 1'b0;
    end
    set_idle();
    rst_n_in = 1'b0;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // reset state
    rf_if.rs1_in[0] = AW'(5);
    #1;
    check("rst_r5_val", rf_if.rval1_out[0], 0);
    check("rst_r5_pend", rf_if.rob1_valid_out[0], 0);
    check("rst_r0_val", rf_if.rval2_out[0], 0);
    check("rst_r0_pend", rf_if.rob2_valid_out[0], 0);
    check("rst_count", rf_if.pending_count_out, 0);
    tick();

    // issue then commit with matching tag
    set_idle(); do_issue(0, 3, 5); tick();
    set_idle(); rf_if.rs1_in[0] = AW'(3); #1;
    check("r3_pend", rf_if.rob1_valid_out[0], 1);
    check("r3_tag", rf_if.rob_ix1_out[0], 5);
    check("r3_count", rf_if.pending_count_out, 1);
    tick();
    set_idle(); do_commit(0, 3, 5, 32'hDEADBEEF); tick();
    set_idle(); rf_if.rs1_in[0] = AW'(3); #1;
    check("r3_val", rf_if.rval1_out[0], 32'hDEADBEEF);
    check("r3_pend_clr", rf_if.rob1_valid_out[0], 0);
    check("r3_count_clr", rf_if.pending_count_out, 0);
    tick();

    // stale-tag commit keeps pending
    set_idle(); do_issue(0, 7, 2); tick();
    set_idle(); do_issue(0, 7, 4); tick();
    set_idle(); do_commit(0, 7, 2, 32'h11); tick();
    set_idle(); rf_if.rs1_in[0] = AW'(7); #1;
    check("r7_val", rf_if.rval1_out[0], 32'h11);
    check("r7_pend", rf_if.rob1_valid_out[0], 1);
    check("r7_tag", rf_if.rob_ix1_out[0], 4);
    check("r7_count", rf_if.pending_count_out, 1);
    tick();

    // intra-group rename and same-rd slot priority
    set_idle(); do_issue(0, 9, 1); rf_if.rs1_in[1] = AW'(9); #1;
    check("ren_pend", rf_if.rob1_valid_out[1], 1);
    check("ren_tag", rf_if.rob_ix1_out[1], 1);
    tick();
    set_idle(); do_issue(0, 9, 1); do_issue(1, 9, 3); tick();
    set_idle(); rf_if.rs2_in[1] = AW'(9); #1;
    check("r9_tag_slot1", rf_if.rob_ix2_out[1], 3);
    tick();

    // flush with simultaneous commit and ignored issue
    set_idle(); do_issue(0, 1, 1); do_issue(1, 2, 2); tick();
    set_idle(); do_issue(0, 3, 3); tick();
    set_idle(); rf_if.flush_in = 1'b1; do_commit(0, 2, 0, 32'h42); do_issue(0, 5, 7); tick();
    set_idle(); rf_if.rs1_in[0] = AW'(2); rf_if.rs2_in[0] = AW'(5); rf_if.rs1_in[1] = AW'(1); #1;
    check("flush_r2_val", rf_if.rval1_out[0], 32'h42);
    check("flush_r2_pend", rf_if.rob1_valid_out[0], 0);
    check("flush_r5_pend", rf_if.rob2_valid_out[0], 0);
    check("flush_r1_pend", rf_if.rob1_valid_out[1], 0);
    check("flush_count", rf_if.pending_count_out, 0);
    tick();

    // commit-to-read bypass (or its absence)
    set_idle(); do_issue(0, 4, 6); tick();
    set_idle(); do_commit(0, 4, 6, 32'h99); rf_if.rs1_in[0] = AW'(4); #1;
`ifdef RF_BYPASS_EN
    check("byp_val", rf_if.rval1_out[0], 32'h99);
    check("byp_pend", rf_if.rob1_valid_out[0], 0);
`else
    check("nobyp_val", rf_if.rval1_out[0], 0);
    check("nobyp_pend", rf_if.rob1_valid_out[0], 1);
`endif
    tick();
    set_idle(); rf_if.rs1_in[0] = AW'(4); #1;
    check("r4_val", rf_if.rval1_out[0], 32'h99);
    check("r4_pend", rf_if.rob1_valid_out[0], 0);
    tick();

    // randomized traffic over a small register window to force collisions
    for (int cyc = 0; cyc < 3000; cyc++) begin
      set_idle();
      rst_n_in       = ($urandom_range(0, 299) != 0);
      rf_if.flush_in = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < NUM_ISSUE; i++) begin
        rf_if.rs1_in[i]    = AW'($urandom_range(0, 7));
        rf_if.rs2_in[i]    = AW'($urandom_range(0, 7));
        rf_if.issue_in[i]  = ($urandom_range(0, 2) == 0);
        rf_if.rd_in[i]     = AW'($urandom_range(0, 7));
        rf_if.rob_ix_in[i] = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
      end
      for (int j = 0; j < NUM_COMMIT; j++) begin
        a = $urandom_range(0, 7);
        rf_if.commit_in[j]      = ($urandom_range(0, 1) == 0);
        rf_if.commit_addr_in[j] = AW'(a);
        rf_if.commit_data_in[j] = $urandom;
        rf_if.commit_rob_ix_in[j] = ($urandom_range(0, 1) == 0) ? mtag[a]
                                    : TAG_W'($urandom_range(0, ROB_DEPTH - 1));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rename_register_file.md
# rename_register_file

Parametrised architectural register file with per-register ROB-tag rename state for the out-of-order core. It supports a configurable number of issue slots, commit ports and ROB depth, and keeps x0 hardwired to zero. Flush clears all rename state in one cycle, and the block maintains a count of in-flight registers. It sits between the issue stage, which reads operands and allocates tags, and the ROB commit stage, which writes back in order.

## Interface
- XLEN, 32, register data width
- NREGS, 32, number of architectural registers (power of two, ≥2)
- ROB_DEPTH, 8, ROB entries; TAG_W = $clog2(ROB_DEPTH)
- NUM_ISSUE, 2, issue slots; each slot has two source read ports and one rd allocation
- NUM_COMMIT, 2, commit (write) ports
- clk_in  input  1  clock; all state updates on rising edge
- rst_n_in  input  1  synchronous, active-low reset
- rs1_in / rs2_in  input  NUM_ISSUE×$clog2(NREGS)  source addresses per slot
- issue_in  input  NUM_ISSUE  slot i allocates a tag for rd this cycle
- rd_in  input  NUM_ISSUE×$clog2(NREGS)  destination per slot
- rob_ix_in  input  NUM_ISSUE×TAG_W  tag allocated per slot
- commit_in  input  NUM_COMMIT  commit port j valid
- commit_addr_in  input  NUM_COMMIT×$clog2(NREGS)  commit destination
- commit_data_in  input  NUM_COMMIT×XLEN  commit value
- commit_rob_ix_in  input  NUM_COMMIT×TAG_W  tag of the committing instruction
- flush_in  input  1  discard all rename state
- rval1_out / rval2_out  output  NUM_ISSUE×XLEN  source values
- rob_ix1_out / rob_ix2_out  output  NUM_ISSUE×TAG_W  producing tag when pending
- rob1_valid_out / rob2_valid_out  output  NUM_ISSUE  source pending (value not yet architectural)
- pending_count_out  output  $clog2(NREGS)+1  number of registers with pending=1

## Operation
- State per register: value[XLEN], tag[TAG_W], pending bit. Register 0: value, tag and pending are held at 0. Writes, issues and commits to x0 are ignored.
- Commit port j, when commit_in[j] and addr≠0:
  - value is written unconditionally.
  - pending is cleared only if commit tag == stored tag and no same-cycle issue targets that register.
  - Higher-index commit port wins on the same address.
- Issue slot i, when issue_in[i], rd≠0 and flush_in=0: tag ← rob_ix_in[i], pending ← 1.
  - Slots are in program order; a higher slot wins on the same rd.
  - Issue beats commit for tag and pending on the same register. The commit value is still written.
- Intra-group rename (combinational): a source of slot i that matches rd of an issuing slot k<i returns tag=rob_ix_in[k], pending=1. The youngest such k is used. This overrides the register state.
- Source x0 always returns value 0, pending 0, tag 0.
- flush_in=1: every pending bit ← 0 and every tag ← 0 next cycle. Issue is ignored. Commits that cycle still write their values.
- Priority per cycle: reset > flush > (issue over commit for rename state).
- pending_count_out is a registered counter. It is updated every cycle by the number of 0→1 transitions minus 1→0 transitions, and is 0 after reset or flush. It never exceeds NREGS-1.

## Timing
- Reset (rst_n_in=0 at an edge): all values, tags and pending bits = 0, pending_count_out = 0. Read outputs therefore show 0/0/0. Reset mid-operation discards everything.
- Reads are combinational from current state plus same-cycle issue inputs. There is zero read latency.
- Commit and issue effects are visible on reads in the cycle after the edge.
- A commit and a read of the same register in the same cycle:
  - The read returns the old state.
  - Exception: the bypass described under Configuration, when RF_BYPASS_EN is defined.
- Flush takes effect at one edge, with no multi-cycle drain.

## Configuration
- RF_BYPASS_EN defined:
  - Condition: a source read is pending, is not renamed intra-group, and matches an active commit port's address and tag in the same cycle.
  - The read returns commit_data_in with pending=0 and tag=0.
  - The highest-index matching port wins.
- RF_BYPASS_EN undefined: no bypass. Reads reflect registered state only; the consumer sees the value one cycle later.

## Test plan
- Reset, then read r5 and r0 -> rval=0, pending=0, pending_count_out=0.
- Issue r3 with tag 5; next cycle commit r3, tag 5, data 0xDEADBEEF -> after the issue, r3 pending=1 and tag=5; after the commit, value=0xDEADBEEF, pending=0, count back to 0.
- Issue r7 tag 2, then issue r7 tag 4, then commit r7 tag 2 data 0x11 -> value=0x11, pending stays 1 with tag 4, count=1.
- Same cycle: slot0 issues r9 tag 1 and slot1 reads rs1=r9 -> slot1 sees pending=1, tag=1. Slot0 and slot1 both issuing r9 -> next cycle tag = slot1's tag.
- Issue r1, r2, r3 pending, then flush_in with a simultaneous commit r2 data 0x42 -> next cycle all pending=0, count=0, r2=0x42. An issue asserted during the flush has no effect.
- With RF_BYPASS_EN: r4 pending with tag 6; in one cycle commit r4 tag 6 data 0x99 while reading r4 -> same-cycle rval=0x99, pending=0. Without the macro -> pending=1 that cycle, and 0x99 the next cycle.
